// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, HD44780 command bytes and cycle helpers for lcd_char_ctrl.
package lcd_pkg;
    typedef enum logic [1:0] {
        REQ_CHAR  = 2'd0,
        REQ_GOTO  = 2'd1,
        REQ_CLEAR = 2'd2,
        REQ_RAW   = 2'd3
    } req_type_e;

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT0, S_INIT1, S_INIT2, S_INIT3, S_IDLE, S_XFER, S_WRAP
    } state_e;

    typedef enum logic [2:0] {
        W_IDLE, W_SETUP, W_EN, W_HOLD, W_WAIT
    } wr_state_e;

    localparam logic [7:0] FUNC_SET  = 8'h38;
    localparam logic [7:0] DISP_ON   = 8'h0C;
    localparam logic [7:0] ENTRY_INC = 8'h06;
    localparam logic [7:0] CLEAR     = 8'h01;
    localparam logic [7:0] SET_DDRAM = 8'h80;

    function automatic logic [6:0] row_base(input logic [1:0] row, input int cols);
        return (row == 2'd0) ? 7'h00 : (row == 2'd1) ? 7'h40 :
               (row == 2'd2) ? 7'(cols) : 7'(cols + 'h40);
    endfunction

    function automatic int ceil_cyc(input longint num, input longint den);
        longint q;
        q = (num + den - 1) / den;
        return (q < 1) ? 1 : int'(q);
    endfunction
endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: one LCD byte write (setup, enable pulse, hold, settle wait).
module lcd_bus_writer
    import lcd_pkg::*;
#(
    parameter int EN_CYC  = 1,
    parameter int CMD_CYC = 1,
    parameter int CLR_CYC = 1,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs,
    input  logic [7:0] data,
    input  logic       long_wait,
    output logic       done,
    output logic [7:0] lcd_dat,
    output logic       lcd_rs,
    output logic       lcd_en
);
    wr_state_e     st, nxt;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          long_q, take;

    assign done   = (st == W_WAIT) && (cnt == '0);
    assign take   = start && (st == W_IDLE || done);
    assign lcd_en = (st == W_EN);

    always_comb begin
        nxt     = st;
        nxt_cnt = (cnt == '0) ? cnt : cnt - CW'(1);
        if (take) begin
            nxt     = W_SETUP;
            nxt_cnt = CW'(1);
        end else if (cnt == '0) begin
            case (st)
                W_SETUP: begin nxt = W_EN;   nxt_cnt = CW'(EN_CYC - 1); end
                W_EN:    begin nxt = W_HOLD; nxt_cnt = CW'(1); end
                W_HOLD:  begin nxt = W_WAIT; nxt_cnt = long_q ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1); end
                W_WAIT:  nxt = W_IDLE;
                default: nxt = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= W_IDLE;
            cnt     <= '0;
            long_q  <= 1'b0;
            lcd_dat <= 8'h00;
            lcd_rs  <= 1'b0;
        end else begin
            st  <= nxt;
            cnt <= nxt_cnt;
            if (take) begin
                long_q  <= long_wait;
                lcd_dat <= data;
                lcd_rs  <= rs;
            end
        end
    end
endmodule

// File: rtl/lcd_char_ctrl.sv
// lcd_char_ctrl: HD44780 character LCD controller with power-up init and request port.
// Define LCD_AUTOWRAP_EN to move the cursor to the next row after the last column.
module lcd_char_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int T_PWRUP_US = 20_000,
    parameter int T_EN_NS    = 500,
    parameter int T_CMD_US   = 50,
    parameter int T_CLR_US   = 2_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_type,
    input  logic [7:0] req_data,
    input  logic [1:0] req_row,
    input  logic [4:0] req_col,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_dat,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);
    localparam int EN_CYC  = ceil_cyc(longint'(CLK_HZ) * T_EN_NS, 1_000_000_000);
    localparam int CMD_CYC = ceil_cyc(longint'(CLK_HZ) * T_CMD_US, 1_000_000);
    localparam int CLR_CYC = ceil_cyc(longint'(CLK_HZ) * T_CLR_US, 1_000_000);
    localparam int PWR_CYC = ceil_cyc(longint'(CLK_HZ) * T_PWRUP_US, 1_000_000);
    localparam int MAX_EC  = (EN_CYC > CMD_CYC) ? EN_CYC : CMD_CYC;
    localparam int MAX_PC  = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    localparam int CW      = $clog2(((MAX_EC > MAX_PC) ? MAX_EC : MAX_PC) + 1);

    state_e        st, nxt;
    logic [CW-1:0] pwr_cnt;
    logic [1:0]    row_q;
    logic [4:0]    col_q;
    logic          xfer_wr, wrap_q, done, wr_start, wr_rs, goto_ok, req_wr, at_end;
    logic [7:0]    wr_byte, goto_byte, wrap_byte;

    assign req_ready = (st == S_IDLE);
    assign busy      = ~req_ready;
    assign lcd_rw    = 1'b0;
    assign goto_ok   = (int'(req_row) < ROWS) && (int'(req_col) < COLS);
    assign req_wr    = (req_type != REQ_GOTO) || goto_ok;
    assign at_end    = (int'(col_q) == COLS - 1);
    assign goto_byte = SET_DDRAM | {1'b0, row_base(req_row, COLS) + 7'(req_col)};
    assign wrap_byte = SET_DDRAM | {1'b0, row_base(row_q, COLS)};

`ifdef LCD_AUTOWRAP_EN
    logic [1:0] next_row;
    assign next_row = (int'(row_q) == ROWS - 1) ? 2'd0 : row_q + 2'd1;
`else
    assign wrap_q = 1'b0;
`endif

    // Each state launches the next write in the cycle the previous one reports done.
    always_comb begin
        nxt      = st;
        wr_start = 1'b0;
        wr_rs    = 1'b0;
        wr_byte  = 8'h00;
        case (st)
            S_PWRUP: if (pwr_cnt == '0) begin nxt = S_INIT0; wr_start = 1'b1; wr_byte = FUNC_SET; end
            S_INIT0: if (done) begin nxt = S_INIT1; wr_start = 1'b1; wr_byte = DISP_ON; end
            S_INIT1: if (done) begin nxt = S_INIT2; wr_start = 1'b1; wr_byte = ENTRY_INC; end
            S_INIT2: if (done) begin nxt = S_INIT3; wr_start = 1'b1; wr_byte = CLEAR; end
            S_INIT3: if (done) nxt = S_IDLE;
            S_IDLE: if (req_valid) begin
                nxt      = S_XFER;
                wr_start = req_wr;
                wr_rs    = (req_type == REQ_CHAR);
                wr_byte  = (req_type == REQ_GOTO) ? goto_byte : (req_type == REQ_CLEAR) ? CLEAR : req_data;
            end
            S_XFER: if (done || !xfer_wr) begin
                nxt      = wrap_q ? S_WRAP : S_IDLE;
                wr_start = wrap_q;
                wr_byte  = wrap_byte;
            end
            S_WRAP: if (done) nxt = S_IDLE;
            default: nxt = S_PWRUP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_PWRUP;
            pwr_cnt   <= CW'(PWR_CYC - 1);
            init_done <= 1'b0;
            row_q     <= 2'd0;
            col_q     <= 5'd0;
            xfer_wr   <= 1'b0;
`ifdef LCD_AUTOWRAP_EN
            wrap_q    <= 1'b0;
`endif
        end else begin
            st <= nxt;
            if (pwr_cnt != '0) pwr_cnt <= pwr_cnt - CW'(1);
            if (st == S_INIT3 && done) init_done <= 1'b1;
            if (st == S_IDLE && req_valid) begin
                xfer_wr <= req_wr;
`ifdef LCD_AUTOWRAP_EN
                wrap_q <= (req_type == REQ_CHAR) && at_end;
                if (req_type == REQ_CHAR) begin
                    row_q <= at_end ? next_row : row_q;
                    col_q <= at_end ? 5'd0 : col_q + 5'd1;
                end
`else
                if (req_type == REQ_CHAR) col_q <= at_end ? col_q : col_q + 5'd1;
`endif
                if (req_type == REQ_GOTO && goto_ok) begin
                    row_q <= req_row;
                    col_q <= req_col;
                end
                if (req_type == REQ_CLEAR) begin
                    row_q <= 2'd0;
                    col_q <= 5'd0;
                end
            end
        end
    end

    lcd_bus_writer #(
        .EN_CYC (EN_CYC),
        .CMD_CYC(CMD_CYC),
        .CLR_CYC(CLR_CYC),
        .CW     (CW)
    ) u_writer (
        .clk      (clk),
        .rst      (rst),
        .start    (wr_start),
        .rs       (wr_rs),
        .data     (wr_byte),
        .long_wait(!wr_rs && wr_byte == CLEAR),
        .done     (done),
        .lcd_dat  (lcd_dat),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en)
    );
endmodule

// File: tb/tb_lcd_char_ctrl.sv
// tb_lcd_char_ctrl: random and directed requests on a 16x2 and a 20x4 controller,
// bus writes checked against a cursor/transaction model.
module tb_lcd_char_ctrl;
    localparam int CLK   = 1_000_000;
    localparam int PWR   = 100;
    localparam longint ENL = (longint'(CLK) * 500 + 999_999_999) / 1_000_000_000;
    localparam int EN_C  = (ENL < 1) ? 1 : int'(ENL);
    localparam int CMD_C = int'((longint'(CLK) * 50 + 999_999) / 1_000_000);
    localparam int CLR_C = int'((longint'(CLK) * 2000 + 999_999) / 1_000_000);

    typedef struct packed {
        logic       inst;
        logic       rs;
        logic [7:0] dat;
        int         w;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid [2];
    logic [1:0] rtype [2];
    logic [7:0] rdata [2];
    logic [1:0] rrow  [2];
    logic [4:0] rcol  [2];
    logic       rdy [2], bsy [2], idn [2], ers [2], erw [2], en [2];
    logic [7:0] edat [2];

    int   compares = 0;
    int   fails    = 0;
    int   cyc      = 0;
    ev_t  evq [$];
    logic [8:0] ex [$];
    int   rise [2], wcnt [2];
    logic enp [2] = '{1'b0, 1'b0};
    logic rw_bad = 1'b0;
    int   mcols [2] = '{16, 20};
    int   mrows [2] = '{2, 4};
    int   mrow [2], mcol [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_char_ctrl #(.CLK_HZ(CLK), .COLS(16), .ROWS(2), .T_PWRUP_US(PWR)) dut0 (
        .clk(clk), .rst(rst), .req_valid(valid[0]), .req_ready(rdy[0]), .req_type(rtype[0]),
        .req_data(rdata[0]), .req_row(rrow[0]), .req_col(rcol[0]), .init_done(idn[0]),
        .busy(bsy[0]), .lcd_dat(edat[0]), .lcd_rs(ers[0]), .lcd_rw(erw[0]), .lcd_en(en[0]));

    lcd_char_ctrl #(.CLK_HZ(CLK), .COLS(20), .ROWS(4), .T_PWRUP_US(PWR)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid[1]), .req_ready(rdy[1]), .req_type(rtype[1]),
        .req_data(rdata[1]), .req_row(rrow[1]), .req_col(rcol[1]), .init_done(idn[1]),
        .busy(bsy[1]), .lcd_dat(edat[1]), .lcd_rs(ers[1]), .lcd_rw(erw[1]), .lcd_en(en[1]));

    // One event per completed enable pulse, with its width and rise cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (en[i] === 1'b1 && enp[i] !== 1'b1) begin rise[i] = cyc; wcnt[i] = 0; end
            if (en[i] === 1'b1) wcnt[i]++;
            if (en[i] !== 1'b1 && enp[i] === 1'b1)
                evq.push_back('{inst: i[0], rs: ers[i], dat: edat[i], w: wcnt[i], cyc: rise[i]});
            if (erw[i] !== 1'b0) rw_bad = 1'b1;
            enp[i] = en[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int base(input int i, input int r);
        return (r == 0) ? 0 : (r == 1) ? 64 : (r == 2) ? mcols[i] : 64 + mcols[i];
    endfunction

    // Expected bus bytes ({rs,data}) and ready-low cycles for one request.
    task automatic model(input int i, input int t, input int d, input int r, input int c, output int lat);
        ex.delete();
        case (t)
            0: begin
                ex.push_back(9'(256 + d));
                if (mcol[i] == mcols[i] - 1) begin
`ifdef LCD_AUTOWRAP_EN
                    mrow[i] = (mrow[i] + 1) % mrows[i];
                    mcol[i] = 0;
                    ex.push_back(9'(128 + base(i, mrow[i])));
`endif
                end else mcol[i]++;
            end
            1: if (r < mrows[i] && c < mcols[i]) begin
                mrow[i] = r;
                mcol[i] = c;
                ex.push_back(9'(128 + base(i, r) + c));
            end
            2: begin
                ex.push_back(9'h001);
                mrow[i] = 0;
                mcol[i] = 0;
            end
            default: ex.push_back(9'(d));
        endcase
        lat = (ex.size() == 0) ? 1 : 0;
        foreach (ex[j]) lat += 2 + EN_C + 2 + ((ex[j] == 9'h001) ? CLR_C : CMD_C);
    endtask

    task automatic send(input int i, input int t, input int d, input int r, input int c, input string tag);
        int lat, n;
        model(i, t, d, r, c, lat);
        @(negedge clk);
        evq.delete();
        check({tag, "_ready_in"}, rdy[i], 1);
        valid[i] = 1'b1; rtype[i] = 2'(t); rdata[i] = 8'(d); rrow[i] = 2'(r); rcol[i] = 5'(c);
        @(posedge clk);
        #1 valid[i] = 1'b0;
        @(negedge clk);
        check({tag, "_busy_hi"}, bsy[i], 1);
        n = 1;
        while (rdy[i] !== 1'b1 && n < 20000) begin
            @(negedge clk);
            if (rdy[i] !== 1'b1) n++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_busy_lo"}, bsy[i], 0);
        check({tag, "_nwrites"}, evq.size(), ex.size());
        for (int j = 0; j < ex.size() && j < evq.size(); j++) begin
            check($sformatf("%s_inst%0d", tag, j), evq[j].inst, i);
            check($sformatf("%s_rs%0d", tag, j), evq[j].rs, ex[j][8]);
            check($sformatf("%s_dat%0d", tag, j), evq[j].dat, ex[j][7:0]);
            check($sformatf("%s_enw%0d", tag, j), evq[j].w, EN_C);
        end
        if (ex.size() > 0) check({tag, "_dat_hold"}, edat[i], ex[ex.size()-1][7:0]);
    endtask

    task automatic check_init();
        int t0, n, k, prev;
        logic [7:0] seq [4];
        seq = '{8'h38, 8'h0C, 8'h06, 8'h01};
        t0 = cyc;
        n = 0;
        while (!(idn[0] === 1'b1 && idn[1] === 1'b1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("init_in_time", n < 5000, 1);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("init_ready%0d", i), rdy[i], 1);
            check($sformatf("init_busy%0d", i), bsy[i], 0);
            k = 0;
            prev = 0;
            foreach (evq[j]) if (evq[j].inst == i[0]) begin
                if (k < 4) begin
                    check($sformatf("init%0d_rs%0d", i, k), evq[j].rs, 0);
                    check($sformatf("init%0d_dat%0d", i, k), evq[j].dat, seq[k]);
                    if (k == 0) check($sformatf("init%0d_pwrup", i),
                                      (evq[j].cyc - t0 >= PWR) && (evq[j].cyc - t0 <= PWR + 3), 1);
                    else check($sformatf("init%0d_gap%0d", i, k), evq[j].cyc - prev, 2 + EN_C + 2 + CMD_C);
                end
                prev = evq[j].cyc;
                k++;
            end
            check($sformatf("init%0d_nwrites", i), k, 4);
            check($sformatf("init%0d_clr_gap", i), cyc - prev, EN_C + 2 + CLR_C);
            mrow[i] = 0;
            mcol[i] = 0;
        end
        evq.delete();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0; rtype[i] = 2'd0; rdata[i] = 8'h00; rrow[i] = 2'd0; rcol[i] = 5'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_en%0d", i), en[i], 0);
            check($sformatf("rst_dat%0d", i), edat[i], 0);
            check($sformatf("rst_rs%0d", i), ers[i], 0);
            check($sformatf("rst_ready%0d", i), rdy[i], 0);
            check($sformatf("rst_busy%0d", i), bsy[i], 1);
            check($sformatf("rst_initdone%0d", i), idn[i], 0);
        end
        rst = 1'b0;
        check_init();

        send(0, 0, 8'h48, 0, 0, "char_H");
        send(0, 1, 0, 1, 5, "goto_1_5");
        send(0, 1, 0, 2, 0, "goto_bad_row");
        send(0, 1, 0, 0, 16, "goto_bad_col");
        send(1, 1, 0, 3, 0, "goto20x4_3_0");
        send(1, 1, 0, 2, 19, "goto20x4_2_19");
        send(0, 3, 8'h01, 0, 0, "raw_clear");
        send(0, 3, 8'h0F, 0, 0, "raw_cmd");
        send(0, 1, 0, 0, 15, "goto_0_15");
        send(0, 0, 8'h41, 0, 0, "char_A_end");
        for (int k = 0; k < 16; k++) send(0, 0, $urandom_range(8'h20, 8'h7E), 0, 0, "char_run");
        send(1, 1, 0, 3, 19, "goto20x4_end");
        send(1, 0, 8'h5A, 0, 0, "char20x4_end");

        for (int k = 0; k < 30; k++)
            send($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
                 $urandom_range(0, 3), $urandom_range(0, 23), "rand");

        @(negedge clk);
        valid[0] = 1'b1; rtype[0] = 2'd2;
        @(posedge clk);
        #1 valid[0] = 1'b0;
        n = 0;
        while (en[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("rst_mid_en_seen", en[0], 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_en", en[0], 0);
        check("rst_mid_dat", edat[0], 0);
        check("rst_mid_ready", rdy[0], 0);
        check("rst_mid_busy", bsy[0], 1);
        check("rst_mid_initdone0", idn[0], 0);
        check("rst_mid_initdone1", idn[1], 0);
        @(negedge clk);
        @(negedge clk);
        evq.delete();
        rst = 1'b0;
        check_init();

        for (int k = 0; k < 6; k++)
            send($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
                 $urandom_range(0, 3), $urandom_range(0, 23), "rand_post");
        check("lcd_rw_low", rw_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
